// File: rtl/sensor_monitor_pkg.sv
// Shared types and constants for the sensor error monitor.
//   chan_state_t : per-channel fault FSM state encoding
//   SENS_*       : bit positions of the W/X/Y/Z sensors inside a channel nibble
package sensor_monitor_pkg;

    typedef enum logic [1:0] {
        OK,
        PEND,
        FAULT
    } chan_state_t;

    localparam int unsigned SENS_W = 3;
    localparam int unsigned SENS_X = 2;
    localparam int unsigned SENS_Y = 1;
    localparam int unsigned SENS_Z = 0;

endpackage

// File: rtl/sensor_chan.sv
// One sensor channel: raw-error equation, persistence filter and fault FSM.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   sens      : channel sensors {W, X, Y, Z}
//   latch_en  : 1 = fault sticky until clear, 0 = fault follows raw error
//   clear     : forces the channel back to OK, discarding any partial count
//   fault     : registered fault flag
//   enter     : high in the cycle whose closing edge moves the channel into FAULT
module sensor_chan
    import sensor_monitor_pkg::*;
#(
    parameter int unsigned PERSIST = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sens,
    input  logic       latch_en,
    input  logic       clear,
    output logic       fault,
    output logic       enter
);

    localparam int unsigned CW = $clog2(PERSIST + 1);

    chan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          raw;

    assign raw = sens[SENS_Z] | (sens[SENS_Y] & (sens[SENS_W] | sens[SENS_X]));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            OK: begin
                if (raw && PERSIST == 1) begin
                    state_d = FAULT;
                    cnt_d   = '0;
                end else if (raw) begin
                    state_d = PEND;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PEND: begin
                if (!raw) begin
                    state_d = OK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(PERSIST - 1)) begin
                    state_d = FAULT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FAULT: begin
                if (!latch_en && !raw) begin
                    state_d = OK;
                end
            end
            default: begin
                state_d = OK;
                cnt_d   = '0;
            end
        endcase
        // clear beats every transition, including a pending entry into FAULT
        if (clear) begin
            state_d = OK;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fault = (state_q == FAULT);
    assign enter = (state_d == FAULT) && (state_q != FAULT);

endmodule

// File: rtl/sensor_monitor.sv
// Multi-channel sensor error monitor.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   sensors      : channel c occupies sensors[4c+3:4c] as {W, X, Y, Z}
//   latch_en     : sticky (1) or live (0) fault flags
//   clear        : returns channels to OK and drops the first-fault capture
//   fault        : per-channel registered fault flags
//   error        : OR of all fault flags
//   fault_count  : saturating count of FAULT entries (only rst clears it)
//   first_valid  : a first fault has been captured since reset/clear
//   first_ch     : lowest channel index among the first entries
module sensor_monitor
    import sensor_monitor_pkg::*;
#(
    parameter  int unsigned NUM_CH  = 4,
    parameter  int unsigned PERSIST = 3,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*NUM_CH-1:0] sensors,
    input  logic                latch_en,
    input  logic                clear,
    output logic [NUM_CH-1:0]   fault,
    output logic                error,
    output logic [CNT_W-1:0]    fault_count,
    output logic                first_valid,
    output logic [IDX_W-1:0]    first_ch
);

    localparam int unsigned ADD_W = $clog2(NUM_CH + 1);
    localparam int unsigned SUM_W = CNT_W + ADD_W;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [NUM_CH-1:0] enter;
    logic [ADD_W-1:0]  n_enter;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  count_d;
    logic [IDX_W-1:0]  first_idx;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        sensor_chan #(
            .PERSIST(PERSIST)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .sens    (sensors[4*c +: 4]),
            .latch_en(latch_en),
            .clear   (clear),
            .fault   (fault[c]),
            .enter   (enter[c])
        );
    end

    assign error = |fault;

    // Popcount of entries, then saturating add in a widened sum
    always_comb begin
        n_enter = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_enter = n_enter + ADD_W'(enter[i]);
        end
        sum     = SUM_W'(fault_count) + SUM_W'(n_enter);
        count_d = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    end

    // Lowest-index entering channel wins
    always_comb begin
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (enter[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_count <= '0;
            first_valid <= 1'b0;
            first_ch    <= '0;
        end else begin
            fault_count <= count_d;
            if (clear) begin
                first_valid <= 1'b0;
                first_ch    <= '0;
            end else if (!first_valid && |enter) begin
                first_valid <= 1'b1;
                first_ch    <= first_idx;
            end
        end
    end

endmodule

// File: tb/tb_sensor_monitor.sv
module tb_sensor_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sensors = '0;
    logic        latch_en = 1'b0;
    logic        clear = 1'b0;

    logic [3:0]  fault;
    logic        error;
    logic [7:0]  fault_count;
    logic        first_valid;
    logic [1:0]  first_ch;

    // Second instance with a 2-bit counter to exercise saturation
    logic [3:0]  fault2;
    logic        error2;
    logic [1:0]  fault_count2;
    logic        first_valid2;
    logic [1:0]  first_ch2;

    always #5 clk = ~clk;

    sensor_monitor #(
        .NUM_CH (4),
        .PERSIST(3),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensors    (sensors),
        .latch_en   (latch_en),
        .clear      (clear),
        .fault      (fault),
        .error      (error),
        .fault_count(fault_count),
        .first_valid(first_valid),
        .first_ch   (first_ch)
    );

    sensor_monitor #(
        .NUM_CH (4),
        .PERSIST(3),
        .CNT_W  (2)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .sensors    (sensors),
        .latch_en   (latch_en),
        .clear      (clear),
        .fault      (fault2),
        .error      (error2),
        .fault_count(fault_count2),
        .first_valid(first_valid2),
        .first_ch   (first_ch2)
    );

    typedef struct {
        logic        r;
        logic [15:0] s;
        logic        le;
        logic        clr;
        logic [3:0]  f;
        logic [7:0]  cnt;
        logic        fv;
        logic [1:0]  fch;
        logic [1:0]  cnt2;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;

    task automatic add(input logic r, input logic [15:0] s, input logic le, input logic clr,
                       input logic [3:0] f, input logic [7:0] cnt, input logic fv,
                       input logic [1:0] fch, input logic [1:0] cnt2);
        vec_t v;
        v.r = r; v.s = s; v.le = le; v.clr = clr;
        v.f = f; v.cnt = cnt; v.fv = fv; v.fch = fch; v.cnt2 = cnt2;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        int   edges;

        // reset
        add(1, 16'h0000, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(1, 16'h0000, 0, 0, 4'b0000, 0, 0, 0, 0);
        // two-cycle glitch on ch1, then idle
        add(0, 16'h0010, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 16'h0010, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 4'b0000, 0, 0, 0, 0);
        // non-error patterns (W, X, Y alone; W&X without Y)
        add(0, 16'h8420, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 16'h2840, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 16'hC800, 0, 0, 4'b0000, 0, 0, 0, 0);
        // ch2 = 0110 qualifies on 3rd edge
        add(0, 16'h0600, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 16'h0600, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 16'h0600, 0, 0, 4'b0100, 1, 1, 2, 1);
        add(0, 16'h0000, 0, 0, 4'b0000, 1, 1, 2, 1);
        // sticky: ch0 = 1010 with latch_en=1
        add(0, 16'h000A, 1, 0, 4'b0000, 1, 1, 2, 1);
        add(0, 16'h000A, 1, 0, 4'b0000, 1, 1, 2, 1);
        add(0, 16'h000A, 1, 0, 4'b0001, 2, 1, 2, 2);
        add(0, 16'h0000, 1, 0, 4'b0001, 2, 1, 2, 2);
        add(0, 16'h0000, 1, 0, 4'b0001, 2, 1, 2, 2);
        add(0, 16'h0000, 0, 0, 4'b0000, 2, 1, 2, 2);
        // live: ch0 drops on first edge sampling raw=0
        add(0, 16'h0001, 0, 0, 4'b0000, 2, 1, 2, 2);
        add(0, 16'h0001, 0, 0, 4'b0000, 2, 1, 2, 2);
        add(0, 16'h0001, 0, 0, 4'b0001, 3, 1, 2, 3);
        add(0, 16'h0000, 0, 0, 4'b0000, 3, 1, 2, 3);
        // clear capture, then ch3 & ch1 simultaneous
        add(0, 16'h0000, 0, 1, 4'b0000, 3, 0, 0, 3);
        add(0, 16'h3030, 0, 0, 4'b0000, 3, 0, 0, 3);
        add(0, 16'h3030, 0, 0, 4'b0000, 3, 0, 0, 3);
        add(0, 16'h3030, 0, 0, 4'b1010, 5, 1, 1, 3);
        add(0, 16'h0000, 0, 0, 4'b0000, 5, 1, 1, 3);
        // clear during active sticky error, re-qualify
        add(0, 16'h0001, 1, 0, 4'b0000, 5, 1, 1, 3);
        add(0, 16'h0001, 1, 0, 4'b0000, 5, 1, 1, 3);
        add(0, 16'h0001, 1, 0, 4'b0001, 6, 1, 1, 3);
        add(0, 16'h0001, 1, 1, 4'b0000, 6, 0, 0, 3);
        add(0, 16'h0001, 1, 0, 4'b0000, 6, 0, 0, 3);
        add(0, 16'h0001, 1, 0, 4'b0000, 6, 0, 0, 3);
        add(0, 16'h0001, 1, 0, 4'b0001, 7, 1, 0, 3);
        add(0, 16'h0000, 0, 0, 4'b0000, 7, 1, 0, 3);
        // clear on the would-be entry edge: nothing captured
        add(0, 16'h0001, 0, 0, 4'b0000, 7, 1, 0, 3);
        add(0, 16'h0001, 0, 0, 4'b0000, 7, 1, 0, 3);
        add(0, 16'h0001, 0, 1, 4'b0000, 7, 0, 0, 3);
        add(0, 16'h0000, 0, 0, 4'b0000, 7, 0, 0, 3);
        // rst mid-PEND discards the partial count and zeroes the counters
        add(0, 16'h0001, 0, 0, 4'b0000, 7, 0, 0, 3);
        add(0, 16'h0001, 0, 0, 4'b0000, 7, 0, 0, 3);
        add(1, 16'h0001, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 16'h0001, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 16'h0001, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 16'h0001, 0, 0, 4'b0001, 1, 1, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst      = vecs[i].r;
            sensors  = vecs[i].s;
            latch_en = vecs[i].le;
            clear    = vecs[i].clr;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("row%0d fault", i), 32'(fault), 32'(e.f));
            chk($sformatf("row%0d error", i), 32'(error), 32'(|e.f));
            chk($sformatf("row%0d fault_count", i), 32'(fault_count), 32'(e.cnt));
            chk($sformatf("row%0d first_valid", i), 32'(first_valid), 32'(e.fv));
            chk($sformatf("row%0d first_ch", i), 32'(first_ch), 32'(e.fch));
            chk($sformatf("row%0d sat_count", i), 32'(fault_count2), 32'(e.cnt2));
        end

        // Latency: ch3 = 0011 held from reset; fault[3] must rise on the 3rd edge
        @(negedge clk);
        rst     = 1'b1;
        sensors = 16'h0000;
        clear   = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        latch_en = 1'b1;
        sensors  = 16'h3000;
        edges    = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (fault[3]) break;
        end
        chk("latency_edges", 32'(edges), 32'd3);
        chk("latency_first_ch", 32'(first_ch), 32'd3);
        chk("latency_count", 32'(fault_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
